// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/stall/flush controller with memory-wait timeout and drain-to-halt.
// Optional stall performance counter enabled by defining PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl #(
    parameter int REG_W       = 4,
    parameter int DRAIN_CYC   = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic             ex_memread_i,
    input  logic             branch_taken_i,
    input  logic             mem_busy_i,
    input  logic             halt_req_i,
    input  logic             resume_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             halted_o,
    output logic             mem_err_o,
    output logic [15:0]      stall_cnt_o
);
    typedef enum logic [1:0] {RUN, MEMWAIT, DRAIN, HALTED} state_t;
    state_t     state_q, state_d;
    logic [7:0] tmo_q, tmo_d;
    logic [3:0] drn_q, drn_d;
    logic       mem_err_q, mem_err_d;
    logic       load_use, pc_w, ifid_w, ifid_f, idex_f;
    assign load_use = ex_memread_i && ex_rd_i != '0 &&
                      ((id_use_rs1_i && ex_rd_i == id_rs1_i) || (id_use_rs2_i && ex_rd_i == id_rs2_i));
    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        drn_d     = drn_q;
        mem_err_d = mem_err_q;
        pc_w      = 1'b0;
        ifid_w    = 1'b0;
        ifid_f    = 1'b0;
        idex_f    = 1'b0;
        case (state_q)
            RUN, MEMWAIT: begin
                if (mem_busy_i) begin
                    state_d = MEMWAIT;
                    tmo_d   = tmo_q + 8'd1;
                    if (tmo_q == 8'(MEM_TIMEOUT)) begin
                        mem_err_d = 1'b1;
                        state_d   = HALTED;
                        tmo_d     = '0;
                    end
                end else begin
                    state_d = RUN;
                    tmo_d   = '0;
                    if (branch_taken_i) begin
                        pc_w   = 1'b1;
                        ifid_f = 1'b1;
                        idex_f = 1'b1;
                    end else if (load_use) begin
                        idex_f = 1'b1;
                    end else begin
                        pc_w   = 1'b1;
                        ifid_w = 1'b1;
                        if (halt_req_i) begin
                            state_d = DRAIN;
                            drn_d   = 4'(DRAIN_CYC);
                        end
                    end
                end
            end
            DRAIN: begin
                if (!mem_busy_i) begin
                    ifid_w  = 1'b1;
                    ifid_f  = 1'b1;
                    drn_d   = drn_q - 4'd1;
                    state_d = (drn_q == 4'd1) ? HALTED : DRAIN;
                end
            end
            HALTED: state_d = (resume_i && !mem_err_q) ? RUN : HALTED;
        endcase
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= RUN;
            tmo_q     <= '0;
            drn_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            drn_q     <= drn_d;
            mem_err_q <= mem_err_d;
        end
    end
    // Outputs are forced low while reset is held, regardless of the clock.
    assign pc_write_o   = pc_w & ~rst_i;
    assign ifid_write_o = ifid_w & ~rst_i;
    assign ifid_flush_o = ifid_f & ~rst_i;
    assign idex_flush_o = idex_f & ~rst_i;
    assign halted_o     = (state_q == HALTED) & ~rst_i;
    assign mem_err_o    = mem_err_q;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [15:0] stall_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            stall_q <= '0;
        else if ((state_q == RUN || state_q == MEMWAIT) && !pc_w && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end
    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: table vectors, directed corner sequences and a randomized run against a rule-level model.
module tb_pipeline_ctrl;
    localparam int REG_W = 4, DRAIN_CYC = 3, MEM_TIMEOUT = 15;
`ifdef PIPELINE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic [REG_W-1:0] rs1 = '0, rs2 = '0, rd = '0;
    logic u1 = 0, u2 = 0, mr = 0, br = 0, busy = 0, halt = 0, res = 0;
    logic pc_write, ifid_write, ifid_flush, idex_flush, halted, mem_err;
    logic [15:0] stall_cnt;
    always #5 clk = ~clk;

    pipeline_ctrl #(.REG_W(REG_W), .DRAIN_CYC(DRAIN_CYC), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst), .id_rs1_i(rs1), .id_rs2_i(rs2), .id_use_rs1_i(u1), .id_use_rs2_i(u2),
        .ex_rd_i(rd), .ex_memread_i(mr), .branch_taken_i(br), .mem_busy_i(busy), .halt_req_i(halt),
        .resume_i(res), .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
        .idex_flush_o(idex_flush), .halted_o(halted), .mem_err_o(mem_err), .stall_cnt_o(stall_cnt));

    int checks = 0, errors = 0;
    bit m_halted, m_err;
    int m_drain, m_streak, m_stall;
    logic o_pc, o_w, o_if, o_ix;

    typedef struct {
        logic [REG_W-1:0] rs1, rs2, rd;
        logic u1, u2, mr, br;
        logic pc, w, f, x, wcare;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_halted = 0; m_err = 0; m_drain = 0; m_streak = 0; m_stall = 0;
    endtask

    task automatic count_stall();
        if (m_stall < 65535) m_stall++;
    endtask

    // Reference: running / draining / halted modes with a busy-streak count.
    task automatic model_step(output bit e_pc, output bit e_w, output bit e_if, output bit e_ix, output bit w_care);
        bit ld;
        ld = mr && rd != 0 && ((u1 && rd == rs1) || (u2 && rd == rs2));
        e_pc = 0; e_w = 0; e_if = 0; e_ix = 0; w_care = 1;
        if (m_halted) begin
            if (res && !m_err) m_halted = 0;
        end else if (m_drain > 0) begin
            if (!busy) begin
                e_w = 1; e_if = 1;
                m_drain--;
                if (m_drain == 0) m_halted = 1;
            end
        end else if (busy) begin
            count_stall();
            if (m_streak == MEM_TIMEOUT) begin
                m_err = 1; m_halted = 1; m_streak = 0;
            end else m_streak++;
        end else begin
            m_streak = 0;
            if (br) begin
                e_pc = 1; e_if = 1; e_ix = 1; w_care = 0;
            end else if (ld) begin
                e_ix = 1;
                count_stall();
            end else begin
                e_pc = 1; e_w = 1;
                if (halt) m_drain = DRAIN_CYC;
            end
        end
    endtask

    task automatic tick();
        bit e_pc, e_w, e_if, e_ix, wc, e_h, e_e;
        int e_st;
        @(negedge clk);
        #1;
        o_pc = pc_write; o_w = ifid_write; o_if = ifid_flush; o_ix = idex_flush;
        e_h = m_halted; e_e = m_err;
        e_st = PERF ? m_stall : 0;
        model_step(e_pc, e_w, e_if, e_ix, wc);
        chk("pc_write", o_pc, e_pc);
        if (wc) chk("ifid_write", o_w, e_w);
        chk("ifid_flush", o_if, e_if);
        chk("idex_flush", o_ix, e_ix);
        chk("halted", halted, e_h);
        chk("mem_err", mem_err, e_e);
        chk("stall_cnt", stall_cnt, e_st[15:0]);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        #2;
        chk("rst_pc_write", pc_write, 0);
        chk("rst_ifid_write", ifid_write, 0);
        chk("rst_halted", halted, 0);
        chk("rst_mem_err", mem_err, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        model_reset();
        rst = 0;
    endtask

    task automatic set_in(input int a1, input int a2, input bit b1, input bit b2, input int d, input bit m, input bit b);
        rs1 = REG_W'(a1); rs2 = REG_W'(a2); u1 = b1; u2 = b2; rd = REG_W'(d); mr = m; br = b;
    endtask

    initial begin
        int burst;
        bit d0, d1, d2, d3, d4;
        tbl[0] = '{4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{4'd3, 4'd0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{4'd2, 4'd5, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{4'd2, 4'd5, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{4'd7, 4'd0, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{4'd3, 4'd0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{4'd1, 4'd2, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{4'd4, 4'd0, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        model_reset();
        #1;
        chk("reset_pc_write", pc_write, 0);
        chk("reset_ifid_write", ifid_write, 0);
        chk("reset_halted", halted, 0);
        chk("reset_stall_cnt", stall_cnt, 0);
        @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 9; i++) begin
            set_in(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd, tbl[i].mr, tbl[i].br);
            @(negedge clk);
            #1;
            chk($sformatf("vec%0d_pc_write", i), pc_write, tbl[i].pc);
            if (tbl[i].wcare) chk($sformatf("vec%0d_ifid_write", i), ifid_write, tbl[i].w);
            chk($sformatf("vec%0d_ifid_flush", i), ifid_flush, tbl[i].f);
            chk($sformatf("vec%0d_idex_flush", i), idex_flush, tbl[i].x);
            model_step(d0, d1, d2, d3, d4);
            @(posedge clk);
            #1;
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        do_reset();
        halt = 1; tick(); halt = 0;
        for (int i = 0; i < DRAIN_CYC; i++) begin
            tick();
            chk("drain_ifid_flush", o_if, 1);
            chk("drain_pc_write", o_pc, 0);
        end
        chk("drain_done_halted", halted, 1);
        res = 1; tick(); res = 0;
        tick();
        chk("resume_pc_write", o_pc, 1);
        busy = 1;
        for (int i = 0; i < 15; i++) tick();
        chk("busy15_not_halted", halted, 0);
        tick();
        chk("timeout_halted", halted, 1);
        chk("timeout_mem_err", mem_err, 1);
        busy = 0; res = 1; tick(); res = 0; tick();
        chk("resume_ignored_on_err", halted, 1);
        do_reset();
        halt = 1; tick(); halt = 0; tick();
        @(negedge clk);
        #2;
        rst = 1;
        #1;
        chk("middrain_pc_write", pc_write, 0);
        chk("middrain_ifid_write", ifid_write, 0);
        chk("middrain_ifid_flush", ifid_flush, 0);
        chk("middrain_idex_flush", idex_flush, 0);
        chk("middrain_halted", halted, 0);
        model_reset();
        #1;
        rst = 0;
        #1;
        chk("post_reset_pc_write", pc_write, 1);
        @(posedge clk);
        #1;
        do_reset();
        set_in(3, 0, 1, 0, 3, 1, 0);
        for (int i = 0; i < 4; i++) tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        busy = 1;
        for (int i = 0; i < 5; i++) tick();
        busy = 0; tick();
        chk("perf_stall_cnt", stall_cnt, PERF ? 16'd9 : 16'd0);
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 6) == 0);
            if (burst > 0) begin
                busy = 1; burst--;
            end else if ($urandom_range(0, 99) < 3) begin
                burst = $urandom_range(5, 20); busy = 1;
            end else busy = $urandom_range(0, 9) == 0;
            halt = $urandom_range(0, 9) == 0;
            res = $urandom_range(0, 4) == 0;
            tick();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter REG_W, default 4: register-specifier width.
REQ-002 Parameter DRAIN_CYC, default 3: bubble-injection cycles before halt completes; legal range 1..15.
REQ-003 Parameter MEM_TIMEOUT, default 15: maximum consecutive mem_busy cycles tolerated; legal range 1..255.
REQ-004 CLK  in  1  single clock; all state SHALL update on posedge(CLK).
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 id_rs1, id_rs2  in  REG_W  source specifiers of the instruction in ID.
REQ-007 id_use_rs1, id_use_rs2  in  1  the corresponding source is actually read.
REQ-008 ex_rd  in  REG_W  destination specifier of the instruction in EX.
REQ-009 ex_memread  in  1  the instruction in EX is a load.
REQ-010 branch_taken  in  1  EX resolved a taken branch or jump this cycle.
REQ-011 mem_busy  in  1  data memory is not ready; the pipeline must freeze.
REQ-012 halt_req  in  1  level request to drain and stop.
REQ-013 resume  in  1  single-cycle pulse that leaves HALTED.
REQ-014 pc_write, ifid_write  out  1  write enables for PC and the IF/ID register.
REQ-015 ifid_flush, idex_flush  out  1  bubble insertion into IF/ID and ID/EX.
REQ-016 halted, mem_err  out  1  status flags.
REQ-017 stall_cnt  out  16  performance counter (see Configuration).

Function
REQ-018 FSM states SHALL be RUN, MEMWAIT, DRAIN and HALTED; the control outputs are a combinational decode of state and inputs.
REQ-019 RUN priority SHALL be: mem_busy > branch_taken > load-use > halt_req > normal.
REQ-020 Load-use is defined as ex_memread & ex_rd!=0 & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
REQ-021 Normal SHALL produce pc_write=1, ifid_write=1, both flushes=0.
REQ-022 mem_busy in RUN or MEMWAIT SHALL produce pc_write=0, ifid_write=0, flushes=0, state MEMWAIT, and timeout counter +1.
REQ-023 MEMWAIT with mem_busy=0 SHALL decode exactly as RUN that cycle, clear the timeout counter, and take the RUN next-state.
REQ-024 The timeout counter reaching MEM_TIMEOUT with mem_busy still 1 SHALL set sticky mem_err and enter HALTED next cycle.
REQ-025 branch_taken SHALL produce pc_write=1, ifid_flush=1, idex_flush=1; a simultaneous load-use is suppressed.
REQ-026 Load-use SHALL produce pc_write=0, ifid_write=0, idex_flush=1 for exactly the cycle the condition holds.
REQ-027 halt_req in RUN with no higher-priority event SHALL enter DRAIN and load the drain counter with DRAIN_CYC.
REQ-028 DRAIN SHALL produce pc_write=0, ifid_write=1, ifid_flush=1, idex_flush=0, decrement the counter, and enter HALTED after DRAIN_CYC cycles; mem_busy during DRAIN freezes the pipeline and pauses the counter.
REQ-029 HALTED SHALL produce all control outputs 0 and halted=1.
REQ-030 resume in HALTED with mem_err=0 SHALL return the FSM to RUN next cycle; resume SHALL be ignored in every other state or when mem_err=1.

Reset
REQ-031 reset=1 SHALL immediately force state RUN, all counters 0, mem_err=0, stall_cnt=0, and all control outputs and halted to 0, independent of CLK.
REQ-032 Reset during MEMWAIT or DRAIN SHALL abandon the operation; the first cycle after release decodes as RUN.

Configuration
REQ-033 With PIPELINE_CTRL_PERF_EN defined, stall_cnt SHALL increment, saturating at 0xFFFF, on every clock edge where pc_write=0 in RUN or MEMWAIT.
REQ-034 Without PIPELINE_CTRL_PERF_EN, stall_cnt SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-035 ex_memread=1, ex_rd=3, id_rs1=3, id_use_rs1=1 for one cycle -> pc_write=0, ifid_write=0, idex_flush=1 for that cycle only; ex_rd=0 with the same stimulus -> no stall.
REQ-036 branch_taken=1 concurrent with the load-use condition -> pc_write=1, ifid_flush=1, idex_flush=1, ifid_write don't-care.
REQ-037 halt_req=1 from RUN -> 3 DRAIN cycles with ifid_flush=1, then halted=1; resume pulse -> RUN and pc_write=1 on the next cycle.
REQ-038 mem_busy held 16 cycles -> mem_err=1 and halted=1 at cycle 16; resume then ignored; reset clears both.
REQ-039 Perf build: 4 load-use cycles plus 5 mem_busy cycles -> stall_cnt=9; no-perf build -> stall_cnt=0.
REQ-040 Reset asserted mid-DRAIN between clock edges -> outputs 0 immediately, state RUN after release.
